// File: rtl/diagnostics_core.sv
// diagnostics_core
//
// SPI-slave diagnostics controller. An external host halts the CPU, reads and
// writes the shadow RAM while halted, streams the VRAM window, and selects the
// active memory configuration.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   halt                 1 = CPU halted, RAM bus owned by this block
//   spi_cs/clk/in        SPI slave inputs (mode 0, async to clk)
//   spi_out              SPI MISO, MSB first, 0 while idle
//   ram_address/wdata    RAM bus address and write data
//   ram_rdata            RAM read data, valid 1 clk after ram_cs
//   ram_we, ram_cs       RAM write strobe / access strobe (1-clk pulses)
//   configuration        boot configuration from the flash loader
//   vram_read_address    VRAM read offset
//   vram_output          VRAM read data, 1 clk latency
//   vram_read_clock      VRAM read clock (same as clk)
//   config_byte          active configuration select
//   vram_size            number of valid VRAM bytes
module diagnostics_core #(
    parameter int CONFIG_BITS = 5,
    parameter int VRAM_AW     = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   halt,
    input  logic                   spi_cs,
    input  logic                   spi_clk,
    input  logic                   spi_in,
    output logic                   spi_out,
    output logic [15:0]            ram_address,
    input  logic [7:0]             ram_rdata,
    output logic [7:0]             ram_wdata,
    output logic                   ram_we,
    output logic                   ram_cs,
    input  logic [CONFIG_BITS-1:0] configuration,
    output logic [VRAM_AW-1:0]     vram_read_address,
    input  logic [7:0]             vram_output,
    output logic                   vram_read_clock,
    output logic [CONFIG_BITS-1:0] config_byte,
    input  logic [VRAM_AW-1:0]     vram_size
);

    localparam logic [7:0] CMD_HALT      = 8'h01;
    localparam logic [7:0] CMD_RUN       = 8'h02;
    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_WRITE     = 8'h04;
    localparam logic [7:0] CMD_SET_CFG   = 8'h05;
    localparam logic [7:0] CMD_READ_VRAM = 8'h06;
    localparam logic [7:0] CMD_GET_CFG   = 8'h07;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_CFG,
        S_STREAM
    } state_t;

    state_t      state;
    logic [7:0]  cmd;
    logic [2:0]  cs_sync;     // [1:0] synchronizer, [2] previous value
    logic [2:0]  sclk_sync;
    logic [1:0]  mosi_sync;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic [7:0]  tx_buf;      // next byte to present, loaded at byte boundary
    logic [7:0]  addr_hi;
    logic        cfg_pending; // GET_CFG still owes the config_byte reply
    logic        vram_req_p0;
    logic        vram_vld_p1;
    logic        ram_vld_p1;

    logic        cs_fall;
    logic        cs_rise;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        in_txn;
    logic        byte_done;
    logic [7:0]  rx_byte;

    // Next VRAM offset: wraps when the following offset would reach vram_size;
    // an empty window pins the offset at 0.
    function automatic logic [VRAM_AW-1:0] next_vram_off(
        input logic [VRAM_AW-1:0] off,
        input logic [VRAM_AW-1:0] size
    );
        logic [VRAM_AW:0] inc;
        inc = {1'b0, off} + (VRAM_AW+1)'(1);
        if (size == '0 || inc == {1'b0, size})
            return '0;
        return inc[VRAM_AW-1:0];
    endfunction

    assign vram_read_clock = clk;
    assign spi_out         = tx_shift[7];

    assign cs_fall   = ~cs_sync[1] &  cs_sync[2];
    assign cs_rise   =  cs_sync[1] & ~cs_sync[2];
    assign sclk_rise =  sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] &  sclk_sync[2];
    assign in_txn    = (state != S_IDLE) && !cs_sync[1];
    assign rx_byte   = {rx_shift[6:0], mosi_sync[1]};
    assign byte_done = in_txn && sclk_rise && (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            cmd               <= 8'h00;
            cs_sync           <= 3'b111;
            sclk_sync         <= 3'b000;
            mosi_sync         <= 2'b00;
            bit_cnt           <= 3'd0;
            rx_shift          <= 8'h00;
            tx_shift          <= 8'h00;
            tx_buf            <= 8'h00;
            addr_hi           <= 8'h00;
            cfg_pending       <= 1'b0;
            vram_req_p0       <= 1'b0;
            vram_vld_p1       <= 1'b0;
            ram_vld_p1        <= 1'b0;
            halt              <= 1'b0;
            ram_cs            <= 1'b0;
            ram_we            <= 1'b0;
            ram_address       <= 16'h0000;
            ram_wdata         <= 8'h00;
            vram_read_address <= '0;
            config_byte       <= configuration;
        end else begin
            cs_sync   <= {cs_sync[1:0], spi_cs};
            sclk_sync <= {sclk_sync[1:0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_in};

            // Strobes are single-cycle unless re-armed below.
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            vram_req_p0 <= 1'b0;

            // --- stage p1: read strobe seen by memory, data arrives next clk
            ram_vld_p1  <= ram_cs & ~ram_we;
            vram_vld_p1 <= vram_req_p0;

            // --- stage p2: capture read data into the tx buffer
            if (ram_vld_p1)
                tx_buf <= ram_rdata;
            if (vram_vld_p1)
                tx_buf <= vram_output;

            // Write address advances the clk after the write pulse.
            if (ram_cs && ram_we)
                ram_address <= ram_address + 16'd1;

            if (cs_rise) begin
                state    <= S_IDLE;
                bit_cnt  <= 3'd0;
                tx_shift <= 8'h00;
            end else if (cs_fall) begin
                state       <= S_CMD;
                bit_cnt     <= 3'd0;
                tx_shift    <= {7'b0, halt};
                tx_buf      <= 8'h00;
                cfg_pending <= 1'b0;
            end else if (in_txn) begin
                if (sclk_rise) begin
                    rx_shift <= rx_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                // bit_cnt is 0 only on the fall that follows a byte's 8th rise.
                if (sclk_fall)
                    tx_shift <= (bit_cnt == 3'd0) ? tx_buf : {tx_shift[6:0], 1'b0};

                if (byte_done) begin
                    tx_buf <= 8'h00;
                    case (state)
                        S_CMD: begin
                            cmd   <= rx_byte;
                            state <= S_STREAM;
                            case (rx_byte)
                                CMD_HALT:    halt <= 1'b1;
                                CMD_RUN:     halt <= 1'b0;
                                CMD_READ,
                                CMD_WRITE:   state <= S_ADDR_HI;
                                CMD_SET_CFG: state <= S_CFG;
                                CMD_READ_VRAM: begin
                                    vram_read_address <= '0;
                                    vram_req_p0       <= 1'b1;
                                end
                                CMD_GET_CFG: begin
                                    tx_buf      <= 8'(configuration);
                                    cfg_pending <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        S_ADDR_HI: begin
                            addr_hi <= rx_byte;
                            state   <= S_ADDR_LO;
                        end
                        S_ADDR_LO: begin
                            ram_address <= {addr_hi, rx_byte};
                            state       <= S_DATA;
                            // Prefetch the first read byte.
                            if (cmd == CMD_READ)
                                ram_cs <= halt;
                        end
                        S_DATA: begin
                            if (cmd == CMD_READ) begin
                                ram_address <= ram_address + 16'd1;
                                ram_cs      <= halt;
                            end else if (halt) begin
                                ram_wdata <= rx_byte;
                                ram_cs    <= 1'b1;
                                ram_we    <= 1'b1;
                            end
                        end
                        S_CFG: begin
                            config_byte <= rx_byte[CONFIG_BITS-1:0];
                            state       <= S_STREAM;
                        end
                        S_STREAM: begin
                            if (cmd == CMD_READ_VRAM) begin
                                vram_read_address <= next_vram_off(vram_read_address, vram_size);
                                vram_req_p0       <= 1'b1;
                            end else if (cmd == CMD_GET_CFG && cfg_pending) begin
                                tx_buf      <= 8'(config_byte);
                                cfg_pending <= 1'b0;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_diagnostics_core.sv
// Testbench for diagnostics_core: table of single-transaction command vectors
// plus hand-written sequences for RAM write/read, run-mode gating, aborted
// bytes and reset mid-transaction.
module tb_diagnostics_core;

    localparam int CB  = 5;
    localparam int VAW = 11;

    logic           clk = 1'b0;
    logic           reset;
    logic           halt;
    logic           spi_cs;
    logic           spi_clk;
    logic           spi_in;
    logic           spi_out;
    logic [15:0]    ram_address;
    logic [7:0]     ram_rdata = 8'h00;
    logic [7:0]     ram_wdata;
    logic           ram_we;
    logic           ram_cs;
    logic [CB-1:0]  configuration;
    logic [VAW-1:0] vram_read_address;
    logic [7:0]     vram_output = 8'h00;
    logic           vram_read_clock;
    logic [CB-1:0]  config_byte;
    logic [VAW-1:0] vram_size;

    diagnostics_core #(.CONFIG_BITS(CB), .VRAM_AW(VAW)) dut (
        .clk(clk), .reset(reset), .halt(halt),
        .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_in(spi_in), .spi_out(spi_out),
        .ram_address(ram_address), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_cs(ram_cs), .configuration(configuration),
        .vram_read_address(vram_read_address), .vram_output(vram_output),
        .vram_read_clock(vram_read_clock), .config_byte(config_byte),
        .vram_size(vram_size)
    );

    always #5 clk = ~clk;

    // RAM contents are a fixed function of the address.
    function automatic logic [7:0] ram_pattern(input logic [15:0] a);
        return a[7:0] + a[15:8] + 8'h21;
    endfunction

    always @(posedge clk) if (ram_cs && !ram_we) ram_rdata <= ram_pattern(ram_address);
    always @(posedge clk) vram_output <= 8'hA0 + vram_read_address[7:0];

    // Strobe monitor
    int          cs_cnt  = 0;
    int          we_wide = 0;
    logic        we_prev = 1'b0;
    logic [15:0] we_addr[$];
    logic [7:0]  we_data[$];
    logic [15:0] rd_addr[$];

    always @(negedge clk) begin
        if (ram_cs) begin
            cs_cnt++;
            if (ram_we) begin
                we_addr.push_back(ram_address);
                we_data.push_back(ram_wdata);
            end else begin
                rd_addr.push_back(ram_address);
            end
        end
        if (ram_we && we_prev) we_wide++;
        we_prev = ram_we;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_begin();
        spi_cs = 1'b0;
        clks(6);
    endtask

    task automatic spi_end();
        clks(6);
        spi_cs = 1'b1;
        clks(8);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            spi_in = tx[i];
            clks(8);
            rx[i]   = spi_out;
            spi_clk = 1'b1;
            clks(8);
            spi_clk = 1'b0;
        end
    endtask

    task automatic run(input logic [47:0] tx, input int n, output logic [47:0] rx);
        logic [7:0] r;
        rx = '0;
        spi_begin();
        for (int i = 0; i < n; i++) begin
            spi_bits(tx[47-8*i -: 8], 8, r);
            rx[47-8*i -: 8] = r;
        end
        spi_end();
    endtask

    typedef struct packed {
        logic [2:0]     n;
        logic [VAW-1:0] vs;
        logic [47:0]    tx;
        logic [47:0]    rx;
        logic           halt;
        logic [CB-1:0]  cfg;
    } vec_t;

    vec_t        vecs[13];
    logic [47:0] rxw;
    logic [7:0]  rb;
    int          c0, w0, r0, wd0;

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // n, vram_size, tx bytes, expected rx bytes, halt after, config_byte after
        vecs[0]  = '{3'd1, 11'd3, 48'h01_00_00_00_00_00, 48'h00_00_00_00_00_00, 1'b1, 5'h0A};
        vecs[1]  = '{3'd1, 11'd3, 48'h02_00_00_00_00_00, 48'h01_00_00_00_00_00, 1'b0, 5'h0A};
        vecs[2]  = '{3'd1, 11'd3, 48'h02_00_00_00_00_00, 48'h00_00_00_00_00_00, 1'b0, 5'h0A};
        vecs[3]  = '{3'd2, 11'd3, 48'h05_03_00_00_00_00, 48'h00_00_00_00_00_00, 1'b0, 5'h03};
        vecs[4]  = '{3'd4, 11'd3, 48'h07_00_00_00_00_00, 48'h00_0A_03_00_00_00, 1'b0, 5'h03};
        vecs[5]  = '{3'd1, 11'd3, 48'h01_00_00_00_00_00, 48'h00_00_00_00_00_00, 1'b1, 5'h03};
        vecs[6]  = '{3'd2, 11'd3, 48'h05_FF_00_00_00_00, 48'h01_00_00_00_00_00, 1'b1, 5'h1F};
        vecs[7]  = '{3'd3, 11'd3, 48'h07_00_00_00_00_00, 48'h01_0A_1F_00_00_00, 1'b1, 5'h1F};
        vecs[8]  = '{3'd3, 11'd3, 48'hAB_00_00_00_00_00, 48'h01_00_00_00_00_00, 1'b1, 5'h1F};
        vecs[9]  = '{3'd6, 11'd3, 48'h06_00_00_00_00_00, 48'h01_A0_A1_A2_A0_A1, 1'b1, 5'h1F};
        vecs[10] = '{3'd4, 11'd0, 48'h06_00_00_00_00_00, 48'h01_A0_A0_A0_00_00, 1'b1, 5'h1F};
        vecs[11] = '{3'd5, 11'd2, 48'h06_00_00_00_00_00, 48'h01_A0_A1_A0_A1_00, 1'b1, 5'h1F};
        vecs[12] = '{3'd2, 11'd3, 48'h05_03_00_00_00_00, 48'h01_00_00_00_00_00, 1'b1, 5'h03};

        spi_cs = 1'b1; spi_clk = 1'b0; spi_in = 1'b0;
        reset = 1'b1; configuration = 5'h0A; vram_size = 11'd3;
        clks(5);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_ram_cs", 32'(ram_cs), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_cfg", 32'(config_byte), 32'h0A);
        check("rst_miso", 32'(spi_out), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_vaddr", 32'(vram_read_address), 32'd0);
        reset = 1'b0;
        clks(8);

        for (int v = 0; v < 13; v++) begin
            vram_size = vecs[v].vs;
            run(vecs[v].tx, int'(vecs[v].n), rxw);
            for (int b = 0; b < int'(vecs[v].n); b++)
                check($sformatf("v%0d_rx%0d", v, b), 32'(rxw[47-8*b -: 8]), 32'(vecs[v].rx[47-8*b -: 8]));
            check($sformatf("v%0d_halt", v), 32'(halt), 32'(vecs[v].halt));
            check($sformatf("v%0d_cfg", v), 32'(config_byte), 32'(vecs[v].cfg));
            check($sformatf("v%0d_miso_idle", v), 32'(spi_out), 32'd0);
        end

        // Halted write: two 1-clk write pulses at 0x8000 and 0x8001.
        c0 = cs_cnt; w0 = we_addr.size(); wd0 = we_wide;
        run(48'h04_80_00_AA_55_00, 5, rxw);
        check("wr_pulses", 32'(we_addr.size() - w0), 32'd2);
        check("wr_cs_pulses", 32'(cs_cnt - c0), 32'd2);
        check("wr_width", 32'(we_wide - wd0), 32'd0);
        if (we_addr.size() >= w0 + 2) begin
            check("wr_addr0", 32'(we_addr[w0]), 32'h8000);
            check("wr_data0", 32'(we_data[w0]), 32'hAA);
            check("wr_addr1", 32'(we_addr[w0+1]), 32'h8001);
            check("wr_data1", 32'(we_data[w0+1]), 32'h55);
        end

        // Halted read across the 0xFFFF -> 0x0000 wrap.
        r0 = rd_addr.size();
        run(48'h03_FF_FF_00_00_00, 5, rxw);
        check("rd_byte0", 32'(rxw[23:16]), 32'h1F);
        check("rd_byte1", 32'(rxw[15:8]), 32'h21);
        check("rd_pulses", 32'(rd_addr.size() - r0), 32'd3);
        if (rd_addr.size() >= r0 + 2) begin
            check("rd_addr0", 32'(rd_addr[r0]), 32'hFFFF);
            check("rd_addr1", 32'(rd_addr[r0+1]), 32'h0000);
        end

        // Running: RAM untouched, reads return zero.
        run(48'h02_00_00_00_00_00, 1, rxw);
        check("run_halt", 32'(halt), 32'd0);
        c0 = cs_cnt;
        run(48'h04_00_10_77_00_00, 4, rxw);
        run(48'h03_00_10_00_00_00, 4, rxw);
        check("run_rd_zero", 32'(rxw[23:16]), 32'h00);
        check("run_no_cs", 32'(cs_cnt - c0), 32'd0);

        // Halted write aborted after 4 bits of the data byte.
        run(48'h01_00_00_00_00_00, 1, rxw);
        c0 = cs_cnt; w0 = we_addr.size();
        spi_begin();
        spi_bits(8'h04, 8, rb);
        spi_bits(8'h00, 8, rb);
        spi_bits(8'h20, 8, rb);
        spi_bits(8'hF0, 4, rb);
        spi_end();
        check("abort_no_we", 32'(we_addr.size() - w0), 32'd0);
        check("abort_no_cs", 32'(cs_cnt - c0), 32'd0);
        run(48'h02_00_00_00_00_00, 1, rxw);
        check("abort_next_status", 32'(rxw[47:40]), 32'h01);
        check("abort_next_halt", 32'(halt), 32'd0);

        // Reset in the middle of a transaction.
        run(48'h01_00_00_00_00_00, 1, rxw);
        spi_begin();
        spi_bits(8'h03, 8, rb);
        spi_bits(8'hA0, 3, rb);
        configuration = 5'h15;
        reset = 1'b1;
        clks(2);
        check("midrst_halt", 32'(halt), 32'd0);
        check("midrst_cfg", 32'(config_byte), 32'h15);
        check("midrst_miso", 32'(spi_out), 32'd0);
        check("midrst_ram_cs", 32'(ram_cs), 32'd0);
        reset = 1'b0;
        spi_end();
        run(48'h07_00_00_00_00_00, 3, rxw);
        check("post_rst_status", 32'(rxw[47:40]), 32'h00);
        check("post_rst_cfg_boot", 32'(rxw[39:32]), 32'h15);
        check("post_rst_cfg_act", 32'(rxw[31:24]), 32'h15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
